// File: rtl/disparity_search.sv
`default_nettype none
// ============================================================================
//  Module   : disparity_search
//  Purpose  : Walks candidate right blocks for one left block, issues one SSD
//             request per disparity and reports the winner-take-all result.
//  Revision : 1.0 - initial release
// ============================================================================
module disparity_search #(
    parameter int MAX_DISP = 16,
    parameter int X_W      = 9,
    parameter int SSD_W    = 23,
    parameter int TIMEOUT  = 64
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       start_in,
    input  logic [X_W-1:0]             left_x_in,
    output logic                       busy_out,
    output logic                       ssd_req_out,
    output logic [X_W-1:0]             left_x_out,
    output logic [X_W-1:0]             right_x_out,
    input  logic                       ssd_valid_in,
    input  logic [SSD_W-1:0]           ssd_in,
    output logic                       done_out,
    output logic [$clog2(MAX_DISP):0]  disparity_out,
    output logic [SSD_W-1:0]           min_ssd_out,
    output logic                       error_out
);

    localparam int DISP_W = $clog2(MAX_DISP) + 1;
    localparam int TMO_W  = $clog2(TIMEOUT) + 1;

    localparam logic [X_W-1:0]    LAST_X_MAX = X_W'(MAX_DISP - 1);
    localparam logic [DISP_W-1:0] LAST_D_MAX = DISP_W'(MAX_DISP - 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT  = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [X_W-1:0]      left_x_q,   left_x_d;
    logic [X_W-1:0]      right_x_q,  right_x_d;
    logic [DISP_W-1:0]   d_q,        d_d;
    logic [DISP_W-1:0]   last_q,     last_d;
    logic [SSD_W-1:0]    best_ssd_q, best_ssd_d;
    logic [DISP_W-1:0]   best_d_q,   best_d_d;
    logic [TMO_W-1:0]    tmo_q,      tmo_d;
    logic [DISP_W-1:0]   disp_q,     disp_d;
    logic [SSD_W-1:0]    min_ssd_q,  min_ssd_d;
    logic                err_q,      err_d;

    logic [DISP_W-1:0]   w_last;
    logic                w_better;
    logic [SSD_W-1:0]    w_best_ssd;
    logic [DISP_W-1:0]   w_best_d;

    // Last disparity index is clamped so right x never goes below zero.
    assign w_last = (left_x_in >= LAST_X_MAX) ? LAST_D_MAX : DISP_W'(left_x_in);

    // Strict compare: on a tie the earlier (smaller) disparity is kept.
    assign w_better   = (ssd_in < best_ssd_q);
    assign w_best_ssd = w_better ? ssd_in : best_ssd_q;
    assign w_best_d   = w_better ? d_q    : best_d_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            left_x_q   <= '0;
            right_x_q  <= '0;
            d_q        <= '0;
            last_q     <= '0;
            best_ssd_q <= '1;
            best_d_q   <= '0;
            tmo_q      <= '0;
            disp_q     <= '0;
            min_ssd_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            left_x_q   <= left_x_d;
            right_x_q  <= right_x_d;
            d_q        <= d_d;
            last_q     <= last_d;
            best_ssd_q <= best_ssd_d;
            best_d_q   <= best_d_d;
            tmo_q      <= tmo_d;
            disp_q     <= disp_d;
            min_ssd_q  <= min_ssd_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        left_x_d   = left_x_q;
        right_x_d  = right_x_q;
        d_d        = d_q;
        last_d     = last_q;
        best_ssd_d = best_ssd_q;
        best_d_d   = best_d_q;
        tmo_d      = tmo_q;
        disp_d     = disp_q;
        min_ssd_d  = min_ssd_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    left_x_d   = left_x_in;
                    right_x_d  = left_x_in;
                    d_d        = '0;
                    last_d     = w_last;
                    best_ssd_d = '1;
                    best_d_d   = '0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result on the limit cycle wins over the timeout.
                if (ssd_valid_in) begin
                    best_ssd_d = w_best_ssd;
                    best_d_d   = w_best_d;
                    if (d_q == last_q) begin
                        disp_d    = w_best_d;
                        min_ssd_d = w_best_ssd;
                        err_d     = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        d_d       = d_q + DISP_W'(1);
                        right_x_d = right_x_q - X_W'(1);
                        state_d   = S_ISSUE;
                    end
                end else if (tmo_q == TMO_LIMIT) begin
                    disp_d    = '0;
                    min_ssd_d = '1;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_out      = (state_q != S_IDLE);
    assign ssd_req_out   = (state_q == S_ISSUE);
    assign done_out      = (state_q == S_DONE);
    assign left_x_out    = left_x_q;
    assign right_x_out   = right_x_q;
    assign disparity_out = disp_q;
    assign min_ssd_out   = min_ssd_q;
    assign error_out     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_disparity_search.sv
`default_nettype none
// ============================================================================
//  Module   : tb_disparity_search
//  Purpose  : Directed, table-driven self-checking bench for disparity_search.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_disparity_search;

    localparam int MAX_DISP = 16;
    localparam int X_W      = 9;
    localparam int SSD_W    = 23;
    localparam int TIMEOUT  = 64;
    localparam int DISP_W   = $clog2(MAX_DISP) + 1;
    localparam int LIMIT    = 2000;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              start_in;
    logic [X_W-1:0]    left_x_in;
    logic              busy_out;
    logic              ssd_req_out;
    logic [X_W-1:0]    left_x_out;
    logic [X_W-1:0]    right_x_out;
    logic              ssd_valid_in;
    logic [SSD_W-1:0]  ssd_in;
    logic              done_out;
    logic [DISP_W-1:0] disparity_out;
    logic [SSD_W-1:0]  min_ssd_out;
    logic              error_out;

    int n_checks = 0;
    int n_fail   = 0;

    disparity_search #(
        .MAX_DISP (MAX_DISP),
        .X_W      (X_W),
        .SSD_W    (SSD_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .start_in      (start_in),
        .left_x_in     (left_x_in),
        .busy_out      (busy_out),
        .ssd_req_out   (ssd_req_out),
        .left_x_out    (left_x_out),
        .right_x_out   (right_x_out),
        .ssd_valid_in  (ssd_valid_in),
        .ssd_in        (ssd_in),
        .done_out      (done_out),
        .disparity_out (disparity_out),
        .min_ssd_out   (min_ssd_out),
        .error_out     (error_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int lx;
        int lat;
        int pat;
        int drop_k;     // request index the engine never answers, -1 for none
        int stray;      // drive spurious valid in IDLE and ISSUE cycles
        int start_mid;  // pulse start_in during WAIT
        int exp_disp;
        int exp_min;
        int exp_err;
        int exp_nreq;
        int exp_done;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ssd_of(input int pat, input int d);
        int a;
        a = (d > 7) ? d - 7 : 7 - d;
        case (pat)
            0:       return (d == 7) ? 500 : 1500 - 10 * a;
            1:       return 1234;
            2:       return (d == 4 || d == 9) ? 10 : 99;
            3:       return 2340900;
            default: return 1000 - d;
        endcase
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int nreq, resp_cyc, busy_err, req_err, rx_err, done_cyc;
        bit done_seen;
        logic [X_W-1:0] rx_exp;
        logic [DISP_W-1:0] disp_hold;
        nreq = 0; resp_cyc = -1; busy_err = 0; req_err = 0; rx_err = 0;
        done_cyc = -1; done_seen = 1'b0;

        @(posedge clk_in); #1;
        start_in     = 1'b1;
        left_x_in    = X_W'(v.lx);
        ssd_valid_in = (v.stray != 0);
        ssd_in       = '0;

        for (int cyc = 1; cyc <= LIMIT && !done_seen; cyc++) begin
            @(posedge clk_in); #1;
            start_in     = 1'b0;
            ssd_valid_in = 1'b0;
            ssd_in       = '0;
            if (busy_out !== 1'b1) busy_err++;
            if (ssd_req_out === 1'b1) begin
                rx_exp = X_W'(v.lx - nreq);
                if (cyc != 1 + nreq * (v.lat + 1)) req_err++;
                if (right_x_out !== rx_exp) rx_err++;
                if (nreq != v.drop_k) resp_cyc = cyc + v.lat;
                nreq++;
                if (v.stray != 0) ssd_valid_in = 1'b1;
            end else if (done_out !== 1'b1 && nreq > 0) begin
                rx_exp = X_W'(v.lx - (nreq - 1));
                if (right_x_out !== rx_exp) rx_err++;
            end
            if (cyc == resp_cyc) begin
                ssd_valid_in = 1'b1;
                ssd_in       = SSD_W'(ssd_of(v.pat, nreq - 1));
            end
            if (v.start_mid != 0 && cyc == 2) begin
                start_in  = 1'b1;
                left_x_in = X_W'(7);
            end
            if (done_out === 1'b1) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end

        $display("vector %0d: left_x=%0d latency=%0d", idx, v.lx, v.lat);
        check("done_seen", done_seen, 1);
        check("done_cycle", done_cyc, v.exp_done);
        check("n_requests", nreq, v.exp_nreq);
        check("disparity", disparity_out, v.exp_disp);
        check("min_ssd", min_ssd_out, v.exp_min);
        check("error", error_out, v.exp_err);
        check("left_x_out", left_x_out, v.lx);
        check("busy_errors", busy_err, 0);
        check("req_timing_errors", req_err, 0);
        check("right_x_errors", rx_err, 0);

        disp_hold = disparity_out;
        @(posedge clk_in); #1;
        check("done_pulse_one_cycle", done_out, 0);
        check("busy_after_done", busy_out, 0);
        check("disparity_held", disparity_out, disp_hold);
    endtask

    initial begin
        int nreq_after;
        vecs[0]  = '{100,  3, 0, -1, 0, 0,  7,     500, 0, 16,  65};
        vecs[1]  = '{  3,  3, 4, -1, 0, 0,  3,     997, 0,  4,  17};
        vecs[2]  = '{ 50,  1, 1, -1, 0, 0,  0,    1234, 0, 16,  33};
        vecs[3]  = '{ 20,  2, 2, -1, 0, 0,  4,      10, 0, 16,  49};
        vecs[4]  = '{200,  5, 3, -1, 0, 0,  0, 2340900, 0, 16,  97};
        vecs[5]  = '{  0,  1, 1, -1, 0, 0,  0,    1234, 0,  1,   3};
        vecs[6]  = '{ 15,  1, 4, -1, 0, 0, 15,     985, 0, 16,  33};
        vecs[7]  = '{100,  2, 0,  1, 0, 0,  0, 8388607, 1,  2,  69};
        vecs[8]  = '{  1, 64, 4, -1, 0, 0,  1,     999, 0,  2, 131};
        vecs[9]  = '{ 40,  2, 1, -1, 1, 0,  0,    1234, 0, 16,  49};
        vecs[10] = '{100,  3, 0, -1, 0, 1,  7,     500, 0, 16,  65};

        rst_in = 1'b0; start_in = 1'b0; left_x_in = '0;
        ssd_valid_in = 1'b0; ssd_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_busy", busy_out, 0);
        check("rst_req", ssd_req_out, 0);
        check("rst_done", done_out, 0);
        check("rst_min_ssd", min_ssd_out, 0);
        rst_in = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Reset asserted while waiting for the first result.
        @(posedge clk_in); #1;
        start_in = 1'b1; left_x_in = X_W'(100);
        @(posedge clk_in); #1;
        start_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        check("midrst_busy", busy_out, 0);
        check("midrst_req", ssd_req_out, 0);
        check("midrst_done", done_out, 0);
        check("midrst_error", error_out, 0);
        check("midrst_disparity", disparity_out, 0);
        check("midrst_min_ssd", min_ssd_out, 0);
        check("midrst_left_x", left_x_out, 0);
        check("midrst_right_x", right_x_out, 0);
        rst_in = 1'b1;
        nreq_after = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_in); #1;
            if (ssd_req_out === 1'b1) nreq_after++;
        end
        check("midrst_no_requests", nreq_after, 0);

        run_vec(11, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
